nec_ir_rx: RTL and testbench

//  Parametrised NEC infrared frame receiver; successor to the fixed 1 MHz IR decoder.

---
 rtl/nec_ir_rx_pkg.sv | 38 +++
 rtl/ir_pulse_timer.sv | 73 +++++++
 rtl/nec_ir_rx.sv | 168 ++++++++++++++++
 tb/tb_nec_ir_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_rx_pkg.sv
// nec_ir_rx_pkg: shared FSM states, nominal NEC widths (us) and the
// tolerance-window helpers used by the receiver.
package nec_ir_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LO,
    LEAD_HI,
    BIT_LO,
    BIT_HI,
    STOP,
    RPT_STOP
  } state_t;

  localparam int LEAD_LO_US = 9000;
  localparam int LEAD_HI_US = 4500;
  localparam int RPT_HI_US  = 2250;
  localparam int ONE_US     = 1690;
  localparam int MARK_US    = 560;
  localparam int TIMEOUT_US = 16383;

  function automatic logic [13:0] win_lo(input int n, input int tol);
    return 14'(n * (100 - tol) / 100);
  endfunction

  function automatic logic [13:0] win_hi(input int n, input int tol);
    return 14'(n * (100 + tol) / 100);
  endfunction

  function automatic logic in_win(
    input logic [13:0] w,
    input logic [13:0] lo,
    input logic [13:0] hi
  );
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: synchroniser, deglitch filter, edge detect and a
// saturating microsecond width counter cleared on every filtered edge.
// Ports: clk, rst_n (sync, active low), ir (async pin) ->
//   rise/fall (1-clk, filtered), width_us (us since last filtered edge).
module ir_pulse_timer
  import nec_ir_rx_pkg::*;
#(
  parameter int CLK_HZ   = 48_000_000,
  parameter int DEGLITCH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir,
  output logic        rise,
  output logic        fall,
  output logic [13:0] width_us
);

  // Below 1 MHz the counter advances several us per clock instead.
  localparam int DIV  = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int STEP = (CLK_HZ >= 1_000_000) ? 1 : 1_000_000 / CLK_HZ;
  localparam int DW   = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic          s1;
  logic          s2;
  logic          filt;
  logic          filt_d;
  logic [DW-1:0] dg_cnt;
  logic [PW-1:0] pre;
  logic          tick;
  logic [14:0]   nxt;

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;
  assign tick = (pre == PW'(DIV - 1));
  assign nxt  = {1'b0, width_us} + 15'(STEP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      dg_cnt   <= '0;
      pre      <= '0;
      width_us <= '0;
    end else begin
      s1     <= ir;
      s2     <= s1;
      filt_d <= filt;
      if (s2 == filt) begin
        dg_cnt <= '0;
      end else if (dg_cnt == DW'(DEGLITCH - 1)) begin
        filt   <= s2;
        dg_cnt <= '0;
      end else begin
        dg_cnt <= dg_cnt + 1'b1;
      end
      if (rise || fall) begin
        pre      <= '0;
        width_us <= '0;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          width_us <= (nxt > 15'(TIMEOUT_US)) ? 14'(TIMEOUT_US)
                                              : nxt[13:0];
        end
      end
    end
  end

endmodule

// File: rtl/nec_ir_rx.sv
// nec_ir_rx: NEC IR frame receiver on the system clock.
// Ports: clk, rst_n (sync, active low), ir (async, active low) ->
//   code/addr of last good frame, valid/rpt/err pulses, rpt_cnt, busy.
module nec_ir_rx
  import nec_ir_rx_pkg::*;
#(
  parameter int CLK_HZ    = 48_000_000,
  parameter int TOL_PCT   = 25,
  parameter int DEGLITCH  = 8,
  parameter bit CHECK_INV = 1'b1,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir,
  output logic [7:0]  code,
  output logic [15:0] addr,
  output logic        valid,
  output logic        rpt,
  output logic [7:0]  rpt_cnt,
  output logic        err,
  output logic        busy
);

  localparam logic [13:0] L9_LO = win_lo(LEAD_LO_US, TOL_PCT);
  localparam logic [13:0] L9_HI = win_hi(LEAD_LO_US, TOL_PCT);
  localparam logic [13:0] L4_LO = win_lo(LEAD_HI_US, TOL_PCT);
  localparam logic [13:0] L4_HI = win_hi(LEAD_HI_US, TOL_PCT);
  localparam logic [13:0] R2_LO = win_lo(RPT_HI_US, TOL_PCT);
  localparam logic [13:0] R2_HI = win_hi(RPT_HI_US, TOL_PCT);
  localparam logic [13:0] B1_LO = win_lo(ONE_US, TOL_PCT);
  localparam logic [13:0] B1_HI = win_hi(ONE_US, TOL_PCT);
  localparam logic [13:0] MK_LO = win_lo(MARK_US, TOL_PCT);
  localparam logic [13:0] MK_HI = win_hi(MARK_US, TOL_PCT);

  logic        rise;
  logic        fall;
  logic [13:0] width_us;
  state_t      state;
  logic [31:0] sr;
  logic [4:0]  idx;
  logic        have_frame;
  logic        w9000;
  logic        w4500;
  logic        w2250;
  logic        w1690;
  logic        w560;
  logic        tmo;
  logic        inv_ok;

  ir_pulse_timer #(
    .CLK_HZ  (CLK_HZ),
    .DEGLITCH(DEGLITCH)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ir      (ir),
    .rise    (rise),
    .fall    (fall),
    .width_us(width_us)
  );

  assign w9000  = in_win(width_us, L9_LO, L9_HI);
  assign w4500  = in_win(width_us, L4_LO, L4_HI);
  assign w2250  = in_win(width_us, R2_LO, R2_HI);
  assign w1690  = in_win(width_us, B1_LO, B1_HI);
  assign w560   = in_win(width_us, MK_LO, MK_HI);
  assign tmo    = (width_us == 14'(TIMEOUT_US));
  assign inv_ok = !CHECK_INV || (sr[23:16] == ~sr[31:24]);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      idx        <= '0;
      have_frame <= 1'b0;
      code       <= '0;
      addr       <= '0;
      valid      <= 1'b0;
      rpt        <= 1'b0;
      rpt_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      valid <= 1'b0;
      rpt   <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) state <= LEAD_LO;
        end
        LEAD_LO: begin
          if (rise) begin
            if (w9000) state <= LEAD_HI;
            else begin err <= 1'b1; state <= IDLE; end
          end
        end
        LEAD_HI: begin
          if (fall) begin
            if (w4500) begin
              idx   <= '0;
              state <= BIT_LO;
            end else if (w2250 && REPEAT_EN) begin
              // Repeat without a prior frame is dropped quietly.
              state <= have_frame ? RPT_STOP : IDLE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        BIT_LO: begin
          if (rise) begin
            if (w560) state <= BIT_HI;
            else begin err <= 1'b1; state <= IDLE; end
          end
        end
        BIT_HI: begin
          if (fall) begin
            if (w560 || w1690) begin
              sr <= {w1690, sr[31:1]};
              if (idx == 5'd31) state <= STOP;
              else begin
                idx   <= idx + 5'd1;
                state <= BIT_LO;
              end
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        STOP: begin
          if (rise) begin
            state <= IDLE;
            if (w560 && inv_ok) begin
              code       <= sr[23:16];
              addr       <= sr[15:0];
              valid      <= 1'b1;
              rpt_cnt    <= '0;
              have_frame <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RPT_STOP: begin
          if (rise) begin
            state <= IDLE;
            if (w560) begin
              rpt <= 1'b1;
              if (rpt_cnt != 8'hFF) rpt_cnt <= rpt_cnt + 8'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Edge-free states only reach here; covers stuck-low and lost stop.
      if (state != IDLE && !rise && !fall && tmo) begin
        err   <= 1'b1;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_rx.sv
// tb_nec_ir_rx: scoreboard bench for nec_ir_rx at a 50 kHz clock (20 us/clk).
// Two receivers share the IR line: inverse check on (a) and off (b).
module tb_nec_ir_rx;
  localparam int DG   = 8;
  localparam int LAT  = DG + 3;
  localparam int EV_N = 0;
  localparam int EV_V = 1;
  localparam int EV_R = 2;
  localparam int EV_E = 3;

  typedef struct {
    int          kind;
    logic [7:0]  code;
    logic [15:0] addr;
    logic [7:0]  cnt;
    int          lo;
    int          hi;
  } ev_t;

  typedef struct {
    bit          rep;
    logic [31:0] data;
    int          pct;
    int          bad;
    int          gap;
    int          ak;
    logic [7:0]  ac;
    logic [15:0] aa;
    logic [7:0]  an;
    int          bk;
    logic [7:0]  bc;
    logic [15:0] ba;
    logic [7:0]  bn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  ev_t         qa[$];
  ev_t         qb[$];
  vec_t        vt[10];
  vec_t        none_rpt;
  ev_t         e;
  logic        seen;

  logic [7:0]  code_a, code_b;
  logic [15:0] addr_a, addr_b;
  logic        valid_a, valid_b, rpt_a, rpt_b, err_a, err_b;
  logic        busy_a, busy_b;
  logic [7:0]  rpt_cnt_a, rpt_cnt_b;

  nec_ir_rx #(
    .CLK_HZ(50_000), .TOL_PCT(25), .DEGLITCH(DG),
    .CHECK_INV(1'b1), .REPEAT_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ir(ir),
    .code(code_a), .addr(addr_a), .valid(valid_a), .rpt(rpt_a),
    .rpt_cnt(rpt_cnt_a), .err(err_a), .busy(busy_a)
  );

  nec_ir_rx #(
    .CLK_HZ(50_000), .TOL_PCT(25), .DEGLITCH(DG),
    .CHECK_INV(1'b0), .REPEAT_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ir(ir),
    .code(code_b), .addr(addr_b), .valid(valid_b), .rpt(rpt_b),
    .rpt_cnt(rpt_cnt_b), .err(err_b), .busy(busy_b)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int ev_kind(input logic v, input logic r, input logic x);
    case ({v, r, x})
      3'b000:  return EV_N;
      3'b100:  return EV_V;
      3'b010:  return EV_R;
      3'b001:  return EV_E;
      default: return 9;
    endcase
  endfunction

  function automatic vec_t mk(
    input bit rep, input logic [31:0] d, input int pct, input int bad,
    input int gap,
    input int ak, input logic [7:0] ac, input logic [15:0] aa,
    input logic [7:0] an,
    input int bk, input logic [7:0] bc, input logic [15:0] ba,
    input logic [7:0] bn
  );
    vec_t v;
    v.rep = rep; v.data = d; v.pct = pct; v.bad = bad; v.gap = gap;
    v.ak = ak; v.ac = ac; v.aa = aa; v.an = an;
    v.bk = bk; v.bc = bc; v.ba = ba; v.bn = bn;
    return v;
  endfunction

  task automatic cmp_ev(input string nm, input int k, input logic [7:0] c,
                        input logic [15:0] a, input logic [7:0] n,
                        input ev_t x);
    chk({nm, "_kind"}, k, x.kind);
    chk({nm, "_code"}, {24'd0, c}, {24'd0, x.code});
    chk({nm, "_addr"}, {16'd0, a}, {16'd0, x.addr});
    chk({nm, "_rpt_cnt"}, {24'd0, n}, {24'd0, x.cnt});
    chk_rng({nm, "_cycle"}, cyc, x.lo, x.hi);
  endtask

  task automatic mon_step();
    int ka;
    int kb;
    ka = ev_kind(valid_a, rpt_a, err_a);
    kb = ev_kind(valid_b, rpt_b, err_b);
    if (ka != EV_N) begin
      if (qa.size() == 0) chk("a_spurious_event", ka, EV_N);
      else cmp_ev("a", ka, code_a, addr_a, rpt_cnt_a, qa.pop_front());
    end
    if (kb != EV_N) begin
      if (qb.size() == 0) chk("b_spurious_event", kb, EV_N);
      else cmp_ev("b", kb, code_b, addr_b, rpt_cnt_b, qb.pop_front());
    end
  endtask

  function automatic int clks(input int us);
    return (us + 10) / 20;
  endfunction

  task automatic seg(input logic lvl, input int us);
    ir = lvl;
    repeat (clks(us)) @(negedge clk);
  endtask

  // Called in the cycle that drives the edge which ends the frame.
  task automatic push(input vec_t v);
    ev_t x;
    if (v.ak != EV_N) begin
      x = '{v.ak, v.ac, v.aa, v.an, cyc + LAT, cyc + LAT};
      qa.push_back(x);
    end
    if (v.bk != EV_N) begin
      x = '{v.bk, v.bc, v.ba, v.bn, cyc + LAT, cyc + LAT};
      qb.push_back(x);
    end
  endtask

  task automatic send_frame(input vec_t v);
    int w;
    seg(1'b0, 9000 * v.pct / 100);
    seg(1'b1, 4500 * v.pct / 100);
    for (int i = 0; i < 32; i++) begin
      seg(1'b0, 560 * v.pct / 100);
      w = v.data[i] ? 1690 : 560;
      if (i == 31 && v.bad != 0) seg(1'b1, w * v.bad / 100);
      else seg(1'b1, w * v.pct / 100);
    end
    if (v.bad != 0) push(v);
    seg(1'b0, 560 * v.pct / 100);
    if (v.bad == 0) push(v);
    seg(1'b1, v.gap);
  endtask

  task automatic send_rpt(input vec_t v);
    seg(1'b0, 9000);
    seg(1'b1, 2250);
    seg(1'b0, 560);
    push(v);
    seg(1'b1, v.gap);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    vt[0] = mk(1'b0, 32'hBA45FF00, 100, 0, 2000,
               EV_V, 8'h45, 16'hFF00, 8'd0, EV_V, 8'h45, 16'hFF00, 8'd0);
    vt[1] = mk(1'b0, 32'hBA45FF00, 120, 0, 2000,
               EV_V, 8'h45, 16'hFF00, 8'd0, EV_V, 8'h45, 16'hFF00, 8'd0);
    vt[2] = mk(1'b0, 32'hBA45FF00, 100, 130, 2000,
               EV_E, 8'h45, 16'hFF00, 8'd0, EV_E, 8'h45, 16'hFF00, 8'd0);
    vt[3] = mk(1'b0, 32'hBB45FF00, 100, 0, 2000,
               EV_E, 8'h45, 16'hFF00, 8'd0, EV_V, 8'h45, 16'hFF00, 8'd0);
    vt[4] = mk(1'b0, 32'hE31C1234, 100, 0, 40000,
               EV_V, 8'h1C, 16'h1234, 8'd0, EV_V, 8'h1C, 16'h1234, 8'd0);
    vt[5] = mk(1'b1, 32'h0, 100, 0, 96190,
               EV_R, 8'h1C, 16'h1234, 8'd1, EV_R, 8'h1C, 16'h1234, 8'd1);
    vt[6] = mk(1'b1, 32'h0, 100, 0, 96190,
               EV_R, 8'h1C, 16'h1234, 8'd2, EV_R, 8'h1C, 16'h1234, 8'd2);
    vt[7] = mk(1'b1, 32'h0, 100, 0, 2000,
               EV_R, 8'h1C, 16'h1234, 8'd3, EV_R, 8'h1C, 16'h1234, 8'd3);
    vt[8] = mk(1'b0, 32'hBA45FF00, 100, 0, 2000,
               EV_V, 8'h45, 16'hFF00, 8'd0, EV_V, 8'h45, 16'hFF00, 8'd0);
    vt[9] = mk(1'b1, 32'h0, 100, 0, 2000,
               EV_R, 8'h45, 16'hFF00, 8'd1, EV_R, 8'h45, 16'hFF00, 8'd1);
    none_rpt = mk(1'b1, 32'h0, 100, 0, 2000,
                  EV_N, 8'h0, 16'h0, 8'd0, EV_N, 8'h0, 16'h0, 8'd0);

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_code", {24'd0, code_a}, 32'h0);
    chk("rst_addr", {16'd0, addr_a}, 32'h0);
    chk("rst_valid", {31'd0, valid_a}, 32'h0);
    chk("rst_rpt", {31'd0, rpt_a}, 32'h0);
    chk("rst_rpt_cnt", {24'd0, rpt_cnt_a}, 32'h0);
    chk("rst_err", {31'd0, err_a}, 32'h0);
    chk("rst_busy", {31'd0, busy_a}, 32'h0);

    send_rpt(none_rpt);
    chk("orphan_rpt_cnt", {24'd0, rpt_cnt_a}, 32'h0);
    chk("orphan_busy", {31'd0, busy_a | busy_b}, 32'h0);

    ir = 1'b0;
    @(negedge clk);
    ir = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | busy_a | busy_b;
    end
    chk("glitch_busy", {31'd0, seen}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].rep) send_rpt(vt[i]);
      else send_frame(vt[i]);
    end

    seg(1'b0, 9000);
    seg(1'b1, 4500);
    for (int i = 0; i <= 12; i++) begin
      seg(1'b0, 560);
      seg(1'b1, vt[0].data[i] ? 1690 : 560);
    end
    chk("mid_busy_before", {31'd0, busy_a}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_code", {24'd0, code_a}, 32'h0);
    chk("mid_addr", {16'd0, addr_a}, 32'h0);
    chk("mid_rpt_cnt", {24'd0, rpt_cnt_a}, 32'h0);
    chk("mid_busy", {31'd0, busy_a}, 32'h0);
    chk("mid_code_b", {24'd0, code_b}, 32'h0);
    chk("mid_rpt_cnt_b", {24'd0, rpt_cnt_b}, 32'h0);
    seg(1'b1, 2000);

    e = '{EV_E, 8'h0, 16'h0, 8'd0, cyc + LAT + 815, cyc + LAT + 827};
    qa.push_back(e);
    qb.push_back(e);
    seg(1'b0, 20000);
    seg(1'b1, 4000);
    chk("stuck_busy", {31'd0, busy_a | busy_b}, 32'h0);
    chk("a_pending_events", qa.size(), 0);
    chk("b_pending_events", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
